led_mode_scheduler: RTL and testbench
=====================================

# led_mode_scheduler

Sequencer for the four-mode LED combiner. It owns the shared 8-bit LED output and decides which of the four pattern blocks (MODE0..MODE3) runs, when it runs, and how fast it runs. It resets each selected mode block before starting it and paces it with a one-cycle step strobe. It advances between modes on a manual request, a direct selection, or automatically after a fixed dwell. It sits between the board controls and the four mode instances; the mode blocks keep their `clk`/`reset`/`en`/`OUT` interface unchanged.

## Interface
- `TICK_DIV`, default 4: clk cycles per step strobe; must be ≥ 2.
- `DWELL`, default 16: step strobes per mode in auto mode; must be ≥ 1.

Ports:
- `clk` in 1: system clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: run enable (level); low forces IDLE.
- `auto` in 1: level; high enables automatic advance after `DWELL` strobes.
- `next` in 1: single-cycle request to advance to the next mode.
- `sel_valid` in 1: single-cycle strobe; jump to the mode given on `sel`.
- `sel` in 2: target mode index, sampled when `sel_valid` is high.
- `mode_out0`..`mode_out3` in 8 each: `OUT` buses from the four mode blocks.
- `mode_en` out 4: per-mode step enable (one-hot or zero), wired to each block's `en`.
- `mode_rst` out 4: per-mode reset pulse (one-hot or zero), ORed into each block's `reset`.
- `led` out 8: registered LED output.
- `cur_mode` out 2: index of the selected mode.
- `busy` out 1: high whenever the FSM is in LOAD or RUN.

## Operation
- FSM states are IDLE, LOAD and RUN.
- Reset values: state = IDLE, `cur_mode` = 0, prescaler = 0, dwell counter = 0, `led` = 0, `mode_en` = 0, `mode_rst` = 0, `busy` = 0.
- IDLE:
  - `start` high → LOAD.
  - `sel_valid` high → `cur_mode` ← `sel`; the FSM stays in IDLE unless `start` is also high.
  - `next` is ignored.
- LOAD (exactly 1 cycle):
  - `mode_rst[cur_mode]` = 1.
  - Prescaler and dwell counter cleared.
  - All inputs ignored, except that `start` low → IDLE.
  - Then → RUN.
- RUN:
  - The prescaler counts 0..`TICK_DIV`-1 and wraps; tick = (prescaler == `TICK_DIV`-1).
  - `mode_en[cur_mode]` = tick; all other `mode_en` bits are 0.
  - The dwell counter increments on each tick.
  - dwell_done = tick & (dwell counter == `DWELL`-1).
- RUN exit priority, highest first:
  1. `start` low → IDLE, `cur_mode` held.
  2. `sel_valid` → `cur_mode` ← `sel`, → LOAD. This applies even when `sel` == `cur_mode` (restart).
  3. `next` → `cur_mode` ← `cur_mode`+1 mod 4 (3 wraps to 0), → LOAD.
  4. `auto` & dwell_done → same as `next`.
- Output mux: `led` ← `mode_out[cur_mode]` when state is RUN, else 0.
- `mode_en` and `mode_rst` are decoded from registered state, so they carry no input-to-output combinational path.
- Asserting `reset` mid-RUN returns everything to the reset values immediately; outputs change without waiting for `clk`.

## Timing
- `start` rising in IDLE, sampled at edge N: LOAD during cycle N+1, RUN from N+2.
- First `mode_en` strobe: the `TICK_DIV`-th cycle of RUN. Subsequent strobes every `TICK_DIV` cycles.
- Auto run length per mode: `DWELL`·`TICK_DIV` RUN cycles, then 1 LOAD cycle. The mode receives exactly `DWELL` strobes, and the final strobe coincides with the transition edge.
- `led` lags `mode_out[cur_mode]` by one cycle. It reads 0 during LOAD, and during the first cycle after any exit from RUN.
- `next` or `sel_valid` in RUN, sampled at edge N: LOAD during cycle N+1, `cur_mode` updated at N+1.
- A tick that coincides with a RUN exit still produces its `mode_en` strobe in that cycle.

## Structure
- Package `led_mode_pkg`:
  - State enum (IDLE, LOAD, RUN).
  - `NUM_MODES` = 4.
  - 2-bit mode index type.
  - 8-bit LED bus type.
- Sub-module `tick_gen`: a `TICK_DIV` prescaler with synchronous clear and count-enable inputs, producing a single-cycle tick. Everything else (FSM, dwell counter, mux, one-hot decode) is in the top module.

## Test plan
Use `TICK_DIV`=4 and `DWELL`=16 unless noted.
1. **Reset:** assert `reset` for 10 ns mid-simulation → all outputs 0 asynchronously, state IDLE, `cur_mode` 0.
2. **Start and pacing:** `start`=1, `auto`=0 → one `mode_rst` = 0001 pulse. `mode_en` = 0001 on RUN cycles 4, 8, 12, …. `led` tracks `mode_out0` with one-cycle lag, and there is no advance after 16 strobes.
3. **Auto cycling:** `auto`=1 → 16 strobes per mode, 65-cycle period. Mode order 0→1→2→3→0, with a `mode_rst` pulse on each entry.
4. **Simultaneous requests:** in RUN with `cur_mode`=1, pulse `next`, `sel_valid` and `sel`=3 together → `cur_mode`=3 (select wins). A separate `next` pulse at `cur_mode`=3 → `cur_mode`=0.
5. **Stop and restart:** drop `start` mid-RUN → IDLE next cycle, then `led`=0, `busy`=0, `mode_en`=0. `sel_valid` with `sel`=2 in IDLE → `cur_mode`=2 with no LOAD. `start`=1 again → `mode_rst`=0100.
6. **Edge parameters:** `TICK_DIV`=2, `DWELL`=1 → strobe every 2nd RUN cycle, and each mode advances after exactly one strobe.

Source files
------------

// File: rtl/led_mode_pkg.sv
// Shared types and constants for the LED mode scheduler.
package led_mode_pkg;

  localparam int unsigned NUM_MODES = 4;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRun
  } state_e;

  typedef logic [1:0] mode_idx_t;
  typedef logic [7:0] led_t;

endpackage

// File: rtl/led_mode_scheduler_tick_gen.sv
// Step-strobe prescaler: counts 0..TICK_DIV-1 while enabled, ticks on the last count.
module tick_gen #(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = $clog2(TICK_DIV);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == CW'(TICK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_mode_scheduler.sv
// Sequences four LED pattern blocks: resets, paces and rotates them, and muxes their output.
module led_mode_scheduler
  import led_mode_pkg::*;
#(
  parameter int unsigned TICK_DIV = 4,
  parameter int unsigned DWELL    = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       auto,
  input  logic       next,
  input  logic       sel_valid,
  input  logic [1:0] sel,
  input  logic [7:0] mode_out0,
  input  logic [7:0] mode_out1,
  input  logic [7:0] mode_out2,
  input  logic [7:0] mode_out3,
  output logic [3:0] mode_en,
  output logic [3:0] mode_rst,
  output logic [7:0] led,
  output logic [1:0] cur_mode,
  output logic       busy
);

  localparam int unsigned DW = (DWELL > 1) ? $clog2(DWELL) : 1;

  state_e          state_q, state_d;
  mode_idx_t       cur_mode_q, cur_mode_d;
  logic [DW-1:0]   dwell_q, dwell_d;
  led_t            led_q, led_d;
  led_t            mode_mux;
  logic            tick, dwell_done, in_run, in_load;
  logic [NUM_MODES-1:0] mode_onehot;

  assign in_run  = (state_q == StRun);
  assign in_load = (state_q == StLoad);

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .reset(reset),
    .clear(in_load),
    .en   (in_run),
    .tick (tick)
  );

  assign dwell_done = tick && (dwell_q == DW'(DWELL - 1));

  always_comb begin
    mode_mux = '0;
    unique case (cur_mode_q)
      2'd0: mode_mux = mode_out0;
      2'd1: mode_mux = mode_out1;
      2'd2: mode_mux = mode_out2;
      2'd3: mode_mux = mode_out3;
      default: mode_mux = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cur_mode_d = cur_mode_q;
    dwell_d    = dwell_q;
    case (state_q)
      StIdle: begin
        if (sel_valid) cur_mode_d = sel;
        if (start) state_d = StLoad;
      end
      StLoad: begin
        dwell_d = '0;
        state_d = start ? StRun : StIdle;
      end
      StRun: begin
        if (tick) dwell_d = dwell_done ? '0 : dwell_q + DW'(1);
        if (!start) begin
          state_d = StIdle;
        end else if (sel_valid) begin
          cur_mode_d = sel;
          state_d    = StLoad;
        end else if (next || (auto && dwell_done)) begin
          cur_mode_d = cur_mode_q + 2'd1;
          state_d    = StLoad;
        end
      end
      default: state_d = StIdle;
    endcase
    // Looking at the next state keeps led at 0 through LOAD and the first cycle after RUN.
    led_d = (state_d == StRun) ? mode_mux : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cur_mode_q <= '0;
      dwell_q    <= '0;
      led_q      <= '0;
    end else begin
      state_q    <= state_d;
      cur_mode_q <= cur_mode_d;
      dwell_q    <= dwell_d;
      led_q      <= led_d;
    end
  end

  assign mode_onehot = 4'b0001 << cur_mode_q;
  assign mode_en     = tick ? mode_onehot : '0;
  assign mode_rst    = in_load ? mode_onehot : '0;
  assign led         = led_q;
  assign cur_mode    = cur_mode_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_led_mode_scheduler.sv
// Directed bench for led_mode_scheduler: default instance plus a TICK_DIV=2/DWELL=1 instance.
module tb_led_mode_scheduler;

  logic       clk = 1'b0;
  logic       reset, start, auto, next, sel_valid;
  logic [1:0] sel;
  logic [7:0] mo0, mo1, mo2, mo3;
  logic [3:0] mode_en, mode_rst, e2_mode_en, e2_mode_rst;
  logic [7:0] led, e2_led;
  logic [1:0] cur_mode, e2_cur_mode;
  logic       busy, e2_busy;

  int passed = 0;
  int total  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  led_mode_scheduler #(.TICK_DIV(4), .DWELL(16)) dut (
    .clk(clk), .reset(reset), .start(start), .auto(auto), .next(next),
    .sel_valid(sel_valid), .sel(sel),
    .mode_out0(mo0), .mode_out1(mo1), .mode_out2(mo2), .mode_out3(mo3),
    .mode_en(mode_en), .mode_rst(mode_rst), .led(led), .cur_mode(cur_mode), .busy(busy)
  );

  led_mode_scheduler #(.TICK_DIV(2), .DWELL(1)) dut2 (
    .clk(clk), .reset(reset), .start(start), .auto(auto), .next(next),
    .sel_valid(sel_valid), .sel(sel),
    .mode_out0(mo0), .mode_out1(mo1), .mode_out2(mo2), .mode_out3(mo3),
    .mode_en(e2_mode_en), .mode_rst(e2_mode_rst), .led(e2_led), .cur_mode(e2_cur_mode),
    .busy(e2_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int n;
    int strobes;
    logic [3:0] exp_oh;
    logic [1:0] m;

    reset = 1'b1; start = 1'b0; auto = 1'b0; next = 1'b0; sel_valid = 1'b0; sel = 2'd0;
    mo0 = 8'hA0; mo1 = 8'hB1; mo2 = 8'hC2; mo3 = 8'hD3;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_led", led, 0);
    chk("rst_en", mode_en, 0);
    chk("rst_rst", mode_rst, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mode", cur_mode, 0);

    // Start with auto off: LOAD pulse, then a strobe every 4th RUN cycle, never advancing.
    start = 1'b1;
    @(negedge clk);
    chk("load_rst", mode_rst, 4'b0001);
    chk("load_busy", busy, 1);
    chk("load_led", led, 0);
    chk("load_en", mode_en, 0);
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      chk("pace_en", mode_en, (k % 4 == 0) ? 4'b0001 : 4'b0000);
      chk("pace_rst", mode_rst, 0);
    end
    chk("noadv_mode", cur_mode, 0);
    chk("noadv_busy", busy, 1);
    chk("led_run", led, 8'hA0);
    mo0 = 8'h5A;
    #1;
    chk("led_lag", led, 8'hA0);
    @(negedge clk);
    chk("led_new", led, 8'h5A);

    // Restart mode 0 with auto on, then check the full 0->1->2->3->0 rotation.
    auto = 1'b1; sel_valid = 1'b1; sel = 2'd0;
    @(negedge clk);
    sel_valid = 1'b0;
    chk("restart_rst", mode_rst, 4'b0001);
    chk("restart_led", led, 0);
    for (int i = 1; i <= 4; i++) begin
      m = 2'(i % 4);
      exp_oh = 4'b0001 << 2'(i - 1);
      n = 0;
      strobes = 0;
      do begin
        @(negedge clk);
        n++;
        if (mode_en == exp_oh) strobes++;
      end while (mode_rst == 4'b0000 && n < 200);
      chk("auto_period", n, 65);
      chk("auto_strobes", strobes, 16);
      chk("auto_mode", cur_mode, m);
      chk("auto_rst", mode_rst, 4'b0001 << m);
    end

    // Simultaneous next + select: select wins; then next wraps 3 -> 0.
    auto = 1'b0;
    @(negedge clk);
    next = 1'b1;
    @(negedge clk);
    next = 1'b0;
    chk("next_mode", cur_mode, 1);
    chk("next_rst", mode_rst, 4'b0010);
    @(negedge clk);
    next = 1'b1; sel_valid = 1'b1; sel = 2'd3;
    @(negedge clk);
    next = 1'b0; sel_valid = 1'b0;
    chk("both_mode", cur_mode, 3);
    chk("both_rst", mode_rst, 4'b1000);
    @(negedge clk);
    next = 1'b1;
    @(negedge clk);
    next = 1'b0;
    chk("wrap_mode", cur_mode, 0);
    chk("wrap_rst", mode_rst, 4'b0001);

    // Stop mid-RUN, select in IDLE, restart.
    @(negedge clk);
    @(negedge clk);
    chk("stop_pre_led", led, 8'h5A);
    start = 1'b0;
    @(negedge clk);
    chk("stop_busy", busy, 0);
    chk("stop_led", led, 0);
    chk("stop_en", mode_en, 0);
    chk("stop_mode", cur_mode, 0);
    sel_valid = 1'b1; sel = 2'd2; next = 1'b1;
    @(negedge clk);
    sel_valid = 1'b0; next = 1'b0;
    chk("idle_sel_mode", cur_mode, 2);
    chk("idle_sel_rst", mode_rst, 0);
    chk("idle_sel_busy", busy, 0);
    start = 1'b1;
    @(negedge clk);
    chk("rerun_rst", mode_rst, 4'b0100);
    chk("rerun_busy", busy, 1);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("rerun_led", led, 8'hC2);

    // Asynchronous reset mid-RUN, away from any clock edge.
    #2 reset = 1'b1;
    #1;
    chk("arst_led", led, 0);
    chk("arst_busy", busy, 0);
    chk("arst_mode", cur_mode, 0);
    chk("arst_en", mode_en, 0);
    chk("arst_rst", mode_rst, 0);
    start = 1'b0;
    #9 reset = 1'b0;
    @(negedge clk);
    chk("arst_idle", busy, 0);

    // TICK_DIV=2, DWELL=1: LOAD, RUN, RUN+strobe, repeating with a new mode each time.
    auto = 1'b1; start = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      exp_oh = 4'b0001 << 2'((k / 3) % 4);
      chk("edge_rst", e2_mode_rst, (k % 3 == 0) ? exp_oh : 4'b0000);
      chk("edge_en", e2_mode_en, (k % 3 == 2) ? exp_oh : 4'b0000);
      chk("edge_mode", e2_cur_mode, (k / 3) % 4);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
